// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory bus between the fetch
// port and the load/store port, one transaction in flight at a time.
// Data port has priority; fetch is forced through after STARVE_MAX losses.
// Optional perf counters are built when MEM_ARB_PERF_EN is defined.
`timescale 1ns/1ps
module mem_port_arbiter #(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned STARVE_MAX = 3,
  parameter int unsigned PERF_W     = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              if_req_i,
  input  logic [AW-1:0]     if_addr_i,
  output logic [DW-1:0]     if_rdata_o,
  output logic              if_done_o,
  output logic              if_stall_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [AW-1:0]     d_addr_i,
  input  logic [DW-1:0]     d_wdata_i,
  input  logic [DW/8-1:0]   d_be_i,
  output logic [DW-1:0]     d_rdata_o,
  output logic              d_done_o,
  output logic              d_stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [AW-1:0]     mem_addr_o,
  output logic [DW-1:0]     mem_wdata_o,
  output logic [DW/8-1:0]   mem_be_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DW-1:0]     mem_rdata_i,
  output logic [PERF_W-1:0] perf_conflict_o,
  output logic [PERF_W-1:0] perf_if_wait_o
);
  localparam int unsigned BW = DW / 8;
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_GNT = 2'd1,
    WAIT_RSP = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          owner_is_d_q, owner_is_d_d;  // 1: data port owns the bus
  logic          abandon_q, abandon_d;        // owner dropped its request in flight
  logic [SW-1:0] starve_q, starve_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [BW-1:0] be_q, be_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          d_wins, if_wins, owner_req;

  // Stalls follow the live request until its done pulse.
  assign if_stall_o = if_req_i & ~if_done_o;
  assign d_stall_o  = d_req_i & ~d_done_o;

  // Arbitration, bus sequencing and response routing.
  always_comb begin
    state_d      = state_q;
    owner_is_d_d = owner_is_d_q;
    abandon_d    = abandon_q;
    starve_d     = starve_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    mem_req_o    = 1'b0;
    if_done_o    = 1'b0;
    d_done_o     = 1'b0;
    d_wins       = d_req_i && (starve_q < SW'(STARVE_MAX));
    if_wins      = !d_wins && if_req_i;
    owner_req    = owner_is_d_q ? d_req_i : if_req_i;

    case (state_q)
      IDLE: begin
        if (d_wins || if_wins) begin
          mem_req_o    = 1'b1;
          owner_is_d_d = d_wins;
          abandon_d    = 1'b0;
          we_d         = d_wins && d_we_i;
          addr_d       = d_wins ? d_addr_i : if_addr_i;
          wdata_d      = d_wins ? d_wdata_i : '0;
          be_d         = d_wins ? d_be_i : '1;
          if (if_wins) begin
            starve_d = '0;
          end else if (if_req_i && (starve_q != SW'(STARVE_MAX))) begin
            starve_d = starve_q + SW'(1);
          end
          state_d = mem_gnt_i ? WAIT_RSP : WAIT_GNT;
        end
      end
      WAIT_GNT: begin
        mem_req_o = 1'b1;
        if (!owner_req) abandon_d = 1'b1;
        if (mem_gnt_i) state_d = WAIT_RSP;
      end
      WAIT_RSP: begin
        if (!owner_req) abandon_d = 1'b1;
        if (mem_rvalid_i) begin
          state_d = IDLE;
          if (owner_req && !abandon_q) begin
            if (owner_is_d_q) begin
              d_done_o  = 1'b1;
              d_rdata_d = mem_rdata_i;
            end else begin
              if_done_o  = 1'b1;
              if_rdata_d = mem_rdata_i;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    mem_we_o    = we_d;
    mem_addr_o  = addr_d;
    mem_wdata_o = wdata_d;
    mem_be_o    = be_d;
    if_rdata_o  = if_rdata_d;
    d_rdata_o   = d_rdata_d;
  end

  // State and captured transaction registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      owner_is_d_q <= 1'b0;
      abandon_q    <= 1'b0;
      starve_q     <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      owner_is_d_q <= owner_is_d_d;
      abandon_q    <= abandon_d;
      starve_q     <= starve_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

`ifdef MEM_ARB_PERF_EN
  logic [PERF_W-1:0] conflict_q, conflict_d, if_wait_q, if_wait_d;

  // Count contended idle cycles and fetch stall cycles, wrapping.
  always_comb begin
    conflict_d = conflict_q + PERF_W'(state_q == IDLE && if_req_i && d_req_i);
    if_wait_d  = if_wait_q + PERF_W'(if_stall_o);
  end

  // Perf counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      conflict_q <= '0;
      if_wait_q  <= '0;
    end else begin
      conflict_q <= conflict_d;
      if_wait_q  <= if_wait_d;
    end
  end

  assign perf_conflict_o = conflict_q;
  assign perf_if_wait_o  = if_wait_q;
`else
  assign perf_conflict_o = '0;
  assign perf_if_wait_o  = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter: a transaction-level
// reference model predicts bus issues and done pulses; a monitor compares.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = 4;
  localparam int unsigned PW = 32;
  localparam int SM    = 3;
  localparam int N_CYC = 4000;
`ifdef MEM_ARB_PERF_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic if_req_i = 1'b0, d_req_i = 1'b0, d_we_i = 1'b0;
  logic [AW-1:0] if_addr_i = '0, d_addr_i = '0;
  logic [DW-1:0] d_wdata_i = '0, mem_rdata_i = '0;
  logic [BW-1:0] d_be_i = '0;
  logic mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0;
  logic [DW-1:0] if_rdata_o, d_rdata_o, mem_wdata_o;
  logic [AW-1:0] mem_addr_o;
  logic [BW-1:0] mem_be_o;
  logic if_done_o, if_stall_o, d_done_o, d_stall_o, mem_req_o, mem_we_o;
  logic [PW-1:0] perf_conflict_o, perf_if_wait_o;

  mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SM), .PERF_W(PW)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o),
    .if_done_o(if_done_o), .if_stall_o(if_stall_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_be_i(d_be_i), .d_rdata_o(d_rdata_o), .d_done_o(d_done_o), .d_stall_o(d_stall_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .perf_conflict_o(perf_conflict_o), .perf_if_wait_o(perf_if_wait_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } bus_t;
  typedef struct {
    int          cyc;
    logic [31:0] data;
  } done_t;

  bus_t  exp_bus[$];
  done_t exp_if[$], exp_d[$];

  int n_checks = 0, n_errors = 0;
  int cyc = 0;
  bit exp_req = 1'b0;
  int exp_conf_now = 0, exp_ifw_now = 0;

  // Reference model state (transaction level).
  bit busy = 0, own_d = 0, dropped = 0;
  int t_issue = 0, t_gnt = 0, t_rsp = 0;
  bit if_act = 0, if_lock = 0, if_donep = 0;
  bit d_act = 0, d_lock = 0, d_donep = 0;
  int m_starve = 0, m_conf = 0, m_ifw = 0;
  logic [31:0] m_if_addr = '0, m_d_addr = '0, m_d_wdata = '0;
  logic [3:0]  m_d_be = '0;
  logic        m_d_we = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", nm, cyc, act, exp);
    end
  endtask

  // One model cycle: requesters, arbitration rule, bus slave, expectations.
  task automatic drive_cycle(input bit allow_new);
    bit idle_now, if_done_now;
    bus_t b;
    done_t dn;
    if (if_donep) if_act = 0;
    if (d_donep) d_act = 0;
    if_donep = 0;
    d_donep  = 0;
    if (busy && cyc > t_issue && !dropped && $urandom_range(0, 19) == 0) begin
      dropped = 1;
      if (own_d) begin d_act = 0; d_lock = 1; end
      else begin if_act = 0; if_lock = 1; end
    end
    if (allow_new && !if_act && !if_lock && $urandom_range(0, 3) != 0) begin
      if_act = 1;
      m_if_addr = $urandom & 32'hFFFF_FFFC;
    end
    if (allow_new && !d_act && !d_lock && $urandom_range(0, 3) != 0) begin
      d_act = 1;
      m_d_we = 1'($urandom_range(0, 1));
      m_d_addr = $urandom & 32'hFFFF_FFFC;
      m_d_wdata = $urandom;
      m_d_be = 4'($urandom_range(1, 15));
    end
    idle_now = !busy;
    if (!busy && (if_act || d_act)) begin
      own_d = d_act && (m_starve < SM);
      if (!own_d) m_starve = 0;
      else if (if_act && m_starve < SM) m_starve = m_starve + 1;
      busy = 1;
      dropped = 0;
      t_issue = cyc;
      t_gnt = cyc + (($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 4)));
      t_rsp = t_gnt + int'($urandom_range(1, 3));
      b.is_d = own_d;
      b.we = own_d ? m_d_we : 1'b0;
      b.addr = own_d ? m_d_addr : m_if_addr;
      b.wdata = m_d_wdata;
      b.be = m_d_be;
      exp_bus.push_back(b);
    end
    exp_req = busy && cyc <= t_gnt;
    mem_gnt_i = exp_req ? (cyc == t_gnt) : 1'($urandom_range(0, 1));
    if (busy && cyc == t_rsp) mem_rvalid_i = 1'b1;
    else if (!busy || cyc < t_gnt) mem_rvalid_i = 1'($urandom_range(0, 1));
    else mem_rvalid_i = 1'b0;
    mem_rdata_i = $urandom;
    if_done_now = 0;
    if (busy && cyc == t_rsp && !dropped) begin
      dn.cyc = cyc;
      dn.data = mem_rdata_i;
      if (own_d) begin exp_d.push_back(dn); d_donep = 1; end
      else begin exp_if.push_back(dn); if_donep = 1; if_done_now = 1; end
    end
    exp_conf_now = m_conf;
    exp_ifw_now = m_ifw;
    if (idle_now && if_act && d_act) m_conf++;
    if (if_act && !if_done_now) m_ifw++;
    if_req_i = if_act;
    if_addr_i = m_if_addr;
    d_req_i = d_act;
    d_we_i = m_d_we;
    d_addr_i = m_d_addr;
    d_wdata_i = m_d_wdata;
    d_be_i = m_d_be;
    if (busy && cyc == t_rsp) begin
      busy = 0;
      if_lock = 0;
      d_lock = 0;
    end
  endtask

  // Asynchronous reset while a response is outstanding; the late rvalid must be ignored.
  task automatic reset_cycle(input bit assert_rst);
    rst_ni = !assert_rst;
    busy = 0; dropped = 0;
    if_act = 0; d_act = 0; if_lock = 0; d_lock = 0; if_donep = 0; d_donep = 0;
    m_starve = 0; m_conf = 0; m_ifw = 0;
    exp_conf_now = 0; exp_ifw_now = 0; exp_req = 0;
    if_req_i = 0; d_req_i = 0; mem_gnt_i = 0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i = $urandom;
  endtask

  // Driver.
  initial begin
    bit rst_want;
    rst_want = 0;
    repeat (3) @(posedge clk);
    #1 rst_ni = 1'b1;
    for (int k = 0; k < N_CYC; k++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (k == 1000 || k == 2200 || k == 3300) rst_want = 1;
      if (rst_want && k < N_CYC - 80 && busy && cyc > t_gnt && cyc < t_rsp) begin
        reset_cycle(1'b1);
        @(posedge clk);
        #1;
        cyc++;
        reset_cycle(1'b0);
        rst_want = 0;
      end else begin
        drive_cycle(k < N_CYC - 60);
      end
    end
    @(negedge clk);
    chk("drain_busy", 64'(busy), 64'd0);
    chk("drain_bus_queue", 64'(exp_bus.size()), 64'd0);
    chk("drain_if_queue", 64'(exp_if.size()), 64'd0);
    chk("drain_d_queue", 64'(exp_d.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Monitor: compares DUT outputs mid-cycle against the scoreboard.
  initial begin
    logic [31:0] last_if, last_d;
    bit if_exp, d_exp;
    bus_t mb;
    last_if = '0;
    last_d = '0;
    forever begin
      @(negedge clk);
      if (!rst_ni) begin
        chk("rst_mem_req", 64'(mem_req_o), 64'd0);
        chk("rst_if_done", 64'(if_done_o), 64'd0);
        chk("rst_d_done", 64'(d_done_o), 64'd0);
        chk("rst_if_rdata", 64'(if_rdata_o), 64'd0);
        chk("rst_d_rdata", 64'(d_rdata_o), 64'd0);
        chk("rst_perf_conflict", 64'(perf_conflict_o), 64'd0);
        chk("rst_perf_if_wait", 64'(perf_if_wait_o), 64'd0);
        chk("rst_if_stall", 64'(if_stall_o), 64'(if_req_i));
        last_if = '0;
        last_d = '0;
      end else begin
        chk("mem_req", 64'(mem_req_o), 64'(exp_req));
        if (mem_req_o && exp_req) begin
          if (exp_bus.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL bus_issue at cycle %0d: request seen with no predicted transaction", cyc);
          end else begin
            mb = exp_bus[0];
            chk("mem_we", 64'(mem_we_o), 64'(mb.we));
            chk("mem_addr", 64'(mem_addr_o), 64'(mb.addr));
            if (mb.is_d) chk("mem_be", 64'(mem_be_o), 64'(mb.be));
            if (mb.we) chk("mem_wdata", 64'(mem_wdata_o), 64'(mb.wdata));
            if (mem_gnt_i) void'(exp_bus.pop_front());
          end
        end
        if_exp = exp_if.size() > 0 && exp_if[0].cyc == cyc;
        d_exp = exp_d.size() > 0 && exp_d[0].cyc == cyc;
        chk("if_done", 64'(if_done_o), 64'(if_exp));
        chk("d_done", 64'(d_done_o), 64'(d_exp));
        if (if_exp) begin
          chk("if_rdata", 64'(if_rdata_o), 64'(exp_if[0].data));
          last_if = exp_if[0].data;
          void'(exp_if.pop_front());
        end else begin
          chk("if_rdata_hold", 64'(if_rdata_o), 64'(last_if));
        end
        if (d_exp) begin
          chk("d_rdata", 64'(d_rdata_o), 64'(exp_d[0].data));
          last_d = exp_d[0].data;
          void'(exp_d.pop_front());
        end else begin
          chk("d_rdata_hold", 64'(d_rdata_o), 64'(last_d));
        end
        chk("if_stall", 64'(if_stall_o), 64'(if_req_i && !if_exp));
        chk("d_stall", 64'(d_stall_o), 64'(d_req_i && !d_exp));
        chk("perf_conflict", 64'(perf_conflict_o), PERF_ON ? 64'(exp_conf_now) : 64'd0);
        chk("perf_if_wait", 64'(perf_if_wait_o), PERF_ON ? 64'(exp_ifw_now) : 64'd0);
      end
    end
  end

endmodule
